sd_block_seq: RTL and testbench

Block-level transfer sequencer for the SD data path. For each block in a requested range it:
- issues CMD17 to the command layer and starts a receive on the D-line driver;
- retries on data CRC failure, then hands the received block to the processing engine;
- issues CMD24 and starts the send, then waits for the card to release busy.

It sits between the top-level controller, the command driver, the D-line driver and the processing engine, and is the only block that pulses their start strobes.

---
 rtl/sd_block_seq_if.sv | 35 +++
 rtl/sd_block_seq.sv | 171 +++++++++++++++++
 tb/tb_sd_block_seq.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_block_seq_if.sv
// Handshake bundle between sd_block_seq and its controller, command, D-line and processing peers.
// master is the sequencer side; slave is everything the sequencer talks to.
interface sd_block_seq_if;
  logic        istart;
  logic [31:0] iblk_first;
  logic [15:0] iblk_count;
  logic        ocmd_start;
  logic [5:0]  ocmd_index;
  logic [31:0] ocmd_arg;
  logic        icmd_done;
  logic        icmd_fail;
  logic        ostart_read;
  logic        ostart_write;
  logic        id_done;
  logic        id_crc_fail;
  logic        oproc_start;
  logic        iproc_done;
  logic        obusy;
  logic        odone;
  logic [1:0]  oerr;

  modport master (
    input  istart, iblk_first, iblk_count, icmd_done, icmd_fail,
           id_done, id_crc_fail, iproc_done,
    output ocmd_start, ocmd_index, ocmd_arg, ostart_read, ostart_write,
           oproc_start, obusy, odone, oerr
  );

  modport slave (
    output istart, iblk_first, iblk_count, icmd_done, icmd_fail,
           id_done, id_crc_fail, iproc_done,
    input  ocmd_start, ocmd_index, ocmd_arg, ostart_read, ostart_write,
           oproc_start, obusy, odone, oerr
  );
endinterface

// File: rtl/sd_block_seq.sv
// Per-block CMD17/read/process/CMD24/write sequencer; Moore strobes one cycle after the deciding edge, waits on peers indefinitely.
// SD_BLOCK_SEQ_TIMEOUT_EN adds a per-wait-state watchdog (TIMEOUT cycles, oerr=3).
module sd_block_seq #(
  parameter int MAX_RETRY = 3
`ifdef SD_BLOCK_SEQ_TIMEOUT_EN
  , parameter logic [23:0] TIMEOUT = 24'd2500000
`endif
) (
  input  logic          iclk,
  input  logic          irst,
  sd_block_seq_if.master bus
);

  localparam logic [3:0] MAX_R  = 4'(MAX_RETRY);
  localparam logic [5:0] IDX_RD = 6'd17;
  localparam logic [5:0] IDX_WR = 6'd24;

  typedef enum logic [3:0] {
    S_IDLE, S_RD_CMD, S_RD_CMD_W, S_RD_GO, S_RD_W, S_PROC, S_PROC_W,
    S_WR_CMD, S_WR_CMD_W, S_WR_GO, S_WR_W, S_NEXT, S_DONE, S_FAIL
  } state_t;

  state_t      state, state_nx;
  logic [31:0] addr;
  logic [15:0] remain;
  logic [3:0]  retry;
  logic [1:0]  err;
  logic        err_set;
  logic [1:0]  err_code;
  logic        retry_inc;
  logic        accept;
  logic        wd_hit;

`ifdef SD_BLOCK_SEQ_TIMEOUT_EN
  logic [23:0] wd;
  logic        in_wait;

  assign in_wait = (state == S_RD_CMD_W) || (state == S_RD_W) || (state == S_PROC_W) ||
                   (state == S_WR_CMD_W) || (state == S_WR_W);
  assign wd_hit  = in_wait && (wd == TIMEOUT - 24'd1);

  // Restarts on every state change so each wait gets the full budget.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst)
      wd <= 24'd0;
    else if (!in_wait || state_nx != state)
      wd <= 24'd0;
    else
      wd <= wd + 24'd1;
  end
`else
  assign wd_hit = 1'b0;
`endif

  assign accept = (state == S_IDLE) && bus.istart;

  always_comb begin
    state_nx  = state;
    err_set   = 1'b0;
    err_code  = 2'd0;
    retry_inc = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.istart)
          state_nx = (bus.iblk_count == 16'd0) ? S_DONE : S_RD_CMD;
      end
      S_RD_CMD: state_nx = S_RD_CMD_W;
      S_RD_CMD_W: begin
        if (bus.icmd_fail) begin
          state_nx = S_FAIL; err_set = 1'b1; err_code = 2'd1;
        end else if (bus.icmd_done) begin
          state_nx = S_RD_GO;
        end else if (wd_hit) begin
          state_nx = S_FAIL; err_set = 1'b1; err_code = 2'd3;
        end
      end
      S_RD_GO: state_nx = S_RD_W;
      S_RD_W: begin
        if (bus.id_done) begin
          if (!bus.id_crc_fail) begin
            state_nx = S_PROC;
          end else if (retry == MAX_R) begin
            state_nx = S_FAIL; err_set = 1'b1; err_code = 2'd2;
          end else begin
            state_nx  = S_RD_CMD;
            retry_inc = 1'b1;
          end
        end else if (wd_hit) begin
          state_nx = S_FAIL; err_set = 1'b1; err_code = 2'd3;
        end
      end
      S_PROC: state_nx = S_PROC_W;
      S_PROC_W: begin
        if (bus.iproc_done) begin
          state_nx = S_WR_CMD;
        end else if (wd_hit) begin
          state_nx = S_FAIL; err_set = 1'b1; err_code = 2'd3;
        end
      end
      S_WR_CMD: state_nx = S_WR_CMD_W;
      S_WR_CMD_W: begin
        if (bus.icmd_fail) begin
          state_nx = S_FAIL; err_set = 1'b1; err_code = 2'd1;
        end else if (bus.icmd_done) begin
          state_nx = S_WR_GO;
        end else if (wd_hit) begin
          state_nx = S_FAIL; err_set = 1'b1; err_code = 2'd3;
        end
      end
      S_WR_GO: state_nx = S_WR_W;
      S_WR_W: begin
        if (bus.id_done) begin
          state_nx = S_NEXT;
        end else if (wd_hit) begin
          state_nx = S_FAIL; err_set = 1'b1; err_code = 2'd3;
        end
      end
      S_NEXT:  state_nx = (remain == 16'd1) ? S_DONE : S_RD_CMD;
      S_DONE:  state_nx = S_IDLE;
      S_FAIL:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state  <= S_IDLE;
      addr   <= 32'd0;
      remain <= 16'd0;
      retry  <= 4'd0;
      err    <= 2'd0;
    end else begin
      state <= state_nx;
      if (accept) begin
        addr   <= bus.iblk_first;
        remain <= bus.iblk_count;
        retry  <= 4'd0;
        err    <= 2'd0;
      end
      // Address wraps modulo 2^32 by design; no overflow check.
      if (state == S_NEXT) begin
        addr   <= addr + 32'd1;
        remain <= remain - 16'd1;
        retry  <= 4'd0;
      end
      if (retry_inc)
        retry <= retry + 4'd1;
      if (err_set)
        err <= err_code;
    end
  end

  always_comb begin
    bus.ocmd_index = 6'd0;
    unique case (state)
      S_RD_CMD, S_RD_CMD_W, S_RD_GO, S_RD_W: bus.ocmd_index = IDX_RD;
      S_WR_CMD, S_WR_CMD_W, S_WR_GO, S_WR_W: bus.ocmd_index = IDX_WR;
      default:                               bus.ocmd_index = 6'd0;
    endcase
  end

  assign bus.ocmd_start   = (state == S_RD_CMD) || (state == S_WR_CMD);
  assign bus.ocmd_arg     = addr;
  assign bus.ostart_read  = (state == S_RD_GO);
  assign bus.ostart_write = (state == S_WR_GO);
  assign bus.oproc_start  = (state == S_PROC);
  assign bus.obusy        = (state != S_IDLE);
  assign bus.odone        = (state == S_DONE);
  assign bus.oerr         = err;

endmodule

// File: tb/tb_sd_block_seq.sv
// Scoreboard bench for sd_block_seq: reactive peer model plus expected strobe queue.
module tb_sd_block_seq;
  logic iclk = 1'b0;
  logic irst = 1'b1;

  sd_block_seq_if bus ();

`ifdef SD_BLOCK_SEQ_TIMEOUT_EN
  sd_block_seq #(.MAX_RETRY(3), .TIMEOUT(24'd100)) dut (.iclk(iclk), .irst(irst), .bus(bus));
`else
  sd_block_seq #(.MAX_RETRY(3)) dut (.iclk(iclk), .irst(irst), .bus(bus));
`endif

  always #5 iclk = ~iclk;

  localparam int K_CMD = 1, K_RD = 2, K_WR = 3, K_PROC = 4, K_DONE = 5;

  logic [63:0] sb[$];
  int n_cmp = 0;
  int n_err = 0;

  // Peer-model knobs.
  int cmd_cd = 0, rd_cd = 0, wr_cd = 0, proc_cd = 0;
  bit cmd_is_wr = 0;
  int reads_to_fail = 0;
  bit fail_wr_cmd = 0;
  bit proc_hang = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ev(input int kind, input logic [5:0] idx, input logic [31:0] arg);
    logic [63:0] r;
    r = {16'd0, 8'(kind), 2'b00, idx, arg};
    return r;
  endfunction

  task automatic push_rd(input logic [31:0] a);
    sb.push_back(ev(K_CMD, 6'd17, a));
    sb.push_back(ev(K_RD, 6'd17, a));
  endtask

  task automatic push_blk(input logic [31:0] a);
    push_rd(a);
    sb.push_back(ev(K_PROC, 6'd0, a));
    sb.push_back(ev(K_CMD, 6'd24, a));
    sb.push_back(ev(K_WR, 6'd24, a));
  endtask

  function automatic logic [63:0] outs();
    return {bus.ocmd_start, bus.ocmd_index, bus.ocmd_arg, bus.ostart_read,
            bus.ostart_write, bus.oproc_start, bus.obusy, bus.odone, bus.oerr};
  endfunction

  // Monitor: every strobe must match the head of the scoreboard.
  initial begin : monitor
    logic [63:0] got;
    bit seen;
    forever begin
      @(negedge iclk);
      seen = 1'b1;
      if (bus.ocmd_start)        got = ev(K_CMD, bus.ocmd_index, bus.ocmd_arg);
      else if (bus.ostart_read)  got = ev(K_RD, bus.ocmd_index, bus.ocmd_arg);
      else if (bus.ostart_write) got = ev(K_WR, bus.ocmd_index, bus.ocmd_arg);
      else if (bus.oproc_start)  got = ev(K_PROC, bus.ocmd_index, bus.ocmd_arg);
      else if (bus.odone)        got = ev(K_DONE, 6'd0, 32'd0);
      else                       seen = 1'b0;
      if (seen) begin
        if (sb.size() == 0) chk("unexpected_ev", got, 64'd0);
        else                chk("ev", got, sb.pop_front());
      end
    end
  end

  // Peer model: command layer, D-line driver and processing engine.
  initial begin : responder
    bus.icmd_done = 0; bus.icmd_fail = 0; bus.id_done = 0;
    bus.id_crc_fail = 0; bus.iproc_done = 0;
    forever begin
      @(negedge iclk);
      bus.icmd_done = 0; bus.icmd_fail = 0; bus.id_done = 0;
      bus.id_crc_fail = 0; bus.iproc_done = 0;
      if (irst) begin
        cmd_cd = 0; rd_cd = 0; wr_cd = 0; proc_cd = 0;
      end else begin
        if (cmd_cd > 0) begin
          cmd_cd--;
          if (cmd_cd == 0) begin
            if (cmd_is_wr && fail_wr_cmd) bus.icmd_fail = 1;
            else                          bus.icmd_done = 1;
          end
        end
        if (rd_cd > 0) begin
          rd_cd--;
          if (rd_cd == 0) begin
            bus.id_done = 1;
            if (reads_to_fail > 0) begin
              bus.id_crc_fail = 1;
              reads_to_fail--;
            end
          end
        end
        if (wr_cd > 0) begin
          wr_cd--;
          if (wr_cd == 0) bus.id_done = 1;
        end
        if (proc_cd > 0) begin
          proc_cd--;
          if (proc_cd == 0) bus.iproc_done = 1;
        end
        if (bus.ocmd_start) begin
          cmd_cd = 2;
          cmd_is_wr = (bus.ocmd_index == 6'd24);
        end
        if (bus.ostart_read)  rd_cd = 3;
        if (bus.ostart_write) wr_cd = 4;
        if (bus.oproc_start && !proc_hang) proc_cd = 2;
      end
    end
  end

  // Drives istart for one cycle and checks the first-cycle reaction.
  task automatic start_job(input logic [31:0] first, input logic [15:0] cnt);
    @(negedge iclk);
    bus.istart = 1; bus.iblk_first = first; bus.iblk_count = cnt;
    @(negedge iclk);
    bus.istart = 0;
    chk("first_cmd_start", {63'd0, bus.ocmd_start}, {63'd0, cnt != 16'd0});
    chk("first_odone", {63'd0, bus.odone}, {63'd0, cnt == 16'd0});
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (bus.obusy && n < budget) begin
      @(negedge iclk);
      n++;
    end
    chk("idle_reached", {63'd0, bus.obusy}, 64'd0);
  endtask

  initial begin : main
    int n;
    bus.istart = 0; bus.iblk_first = 0; bus.iblk_count = 0;
    repeat (3) @(negedge iclk);
    chk("reset_outs", outs(), 64'd0);
    irst = 0;

    // Two clean blocks; a stray istart mid-job must be ignored.
    push_blk(32'h100); push_blk(32'h101);
    sb.push_back(ev(K_DONE, 6'd0, 32'd0));
    start_job(32'h100, 16'd2);
    @(negedge iclk);
    bus.istart = 1; bus.iblk_first = 32'hDEAD; bus.iblk_count = 16'd5;
    @(negedge iclk);
    bus.istart = 0;
    wait_idle(500);
    chk("t1_oerr", {62'd0, bus.oerr}, 64'd0);
    chk("t1_sb_empty", 64'(sb.size()), 64'd0);

    // Two CRC failures, then success.
    reads_to_fail = 2;
    push_rd(32'h100); push_rd(32'h100); push_blk(32'h100);
    sb.push_back(ev(K_DONE, 6'd0, 32'd0));
    start_job(32'h100, 16'd1);
    wait_idle(500);
    chk("t2_oerr", {62'd0, bus.oerr}, 64'd0);
    chk("t2_sb_empty", 64'(sb.size()), 64'd0);

    // Every read fails: four attempts, then retries exhausted.
    reads_to_fail = 100;
    for (int i = 0; i < 4; i++) push_rd(32'h100);
    start_job(32'h100, 16'd1);
    wait_idle(500);
    reads_to_fail = 0;
    chk("t3_oerr", {62'd0, bus.oerr}, 64'd2);
    chk("t3_sb_empty", 64'(sb.size()), 64'd0);

    // Command failure on the write command.
    fail_wr_cmd = 1;
    push_rd(32'h200);
    sb.push_back(ev(K_PROC, 6'd0, 32'h200));
    sb.push_back(ev(K_CMD, 6'd24, 32'h200));
    start_job(32'h200, 16'd1);
    n = 0;
    do begin
      @(posedge iclk);
      n++;
    end while (!bus.icmd_fail && n < 200);
    chk("t4_fail_seen", {63'd0, bus.icmd_fail}, 64'd1);
    @(negedge iclk);
    chk("t4_busy_in_fail", {63'd0, bus.obusy}, 64'd1);
    chk("t4_oerr", {62'd0, bus.oerr}, 64'd1);
    @(negedge iclk);
    chk("t4_idle_after_2", {63'd0, bus.obusy}, 64'd0);
    fail_wr_cmd = 0;
    chk("t4_sb_empty", 64'(sb.size()), 64'd0);

    // Zero-length job.
    sb.push_back(ev(K_DONE, 6'd0, 32'd0));
    start_job(32'h300, 16'd0);
    wait_idle(20);
    chk("t5_oerr", {62'd0, bus.oerr}, 64'd0);
    chk("t5_sb_empty", 64'(sb.size()), 64'd0);

    // Address wrap across 0xFFFFFFFF.
    push_blk(32'hFFFF_FFFF); push_blk(32'h0);
    sb.push_back(ev(K_DONE, 6'd0, 32'd0));
    start_job(32'hFFFF_FFFF, 16'd2);
    wait_idle(500);
    chk("t6_oerr", {62'd0, bus.oerr}, 64'd0);
    chk("t6_sb_empty", 64'(sb.size()), 64'd0);

    // Reset while waiting on the processing engine.
    proc_hang = 1;
    push_rd(32'h400);
    sb.push_back(ev(K_PROC, 6'd0, 32'h400));
    start_job(32'h400, 16'd1);
    n = 0;
    while (!bus.oproc_start && n < 200) begin
      @(negedge iclk);
      n++;
    end
    chk("t7_proc_seen", {63'd0, bus.oproc_start}, 64'd1);
    repeat (2) @(negedge iclk);
    chk("t7_busy_before_rst", {63'd0, bus.obusy}, 64'd1);
    irst = 1;
    #1;
    chk("t7_async_rst_outs", outs(), 64'd0);
    @(negedge iclk);
    irst = 0;
    proc_hang = 0;
    chk("t7_sb_empty", 64'(sb.size()), 64'd0);

    push_blk(32'h500);
    sb.push_back(ev(K_DONE, 6'd0, 32'd0));
    start_job(32'h500, 16'd1);
    wait_idle(500);
    chk("t8_oerr", {62'd0, bus.oerr}, 64'd0);
    chk("t8_sb_empty", 64'(sb.size()), 64'd0);

`ifdef SD_BLOCK_SEQ_TIMEOUT_EN
    // Watchdog: processing never completes.
    proc_hang = 1;
    push_rd(32'h600);
    sb.push_back(ev(K_PROC, 6'd0, 32'h600));
    start_job(32'h600, 16'd1);
    n = 0;
    while (!bus.oproc_start && n < 200) begin
      @(negedge iclk);
      n++;
    end
    n = 0;
    while (bus.oerr != 2'd3 && n < 300) begin
      @(negedge iclk);
      n++;
    end
    chk("t9_wd_cycles", 64'(n), 64'd101);
    chk("t9_oerr", {62'd0, bus.oerr}, 64'd3);
    wait_idle(20);
    proc_hang = 0;
    chk("t9_sb_empty", 64'(sb.size()), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
